energy_seq: RTL and testbench
=============================

Name: energy_seq

Overview:
- Sequencer that drives the energy datapath (square + eadder).
- On a start pulse it reads a frame of 16-bit samples from sample RAM and issues square/accumulate enables aligned to the datapath pipeline.
- It owns the 39-bit result register ereg_out, which is fed back to the eadder and read by downstream blocks.
- It sits between the top-level frame controller and the energy datapath.

Parameters:
- ADDR_W, 8, sample RAM address width; maximum frame length is 2^ADDR_W.
- LEN_W, 9, width of the len port (ADDR_W+1, so a full 256-sample frame is encodable).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a frame; sampled only in IDLE
- cont  input  1  0 = new energy (start from 0); 1 = continue from current ereg_out
- base_addr  input  ADDR_W  first sample address, latched at start
- len  input  LEN_W  number of samples, latched at start; legal range 0..2^ADDR_W
- ram_rd  output  1  sample RAM read strobe (synchronous RAM, data valid next cycle)
- ram_addr  output  ADDR_W  sample RAM read address
- square_en  output  1  enable to square block, one cycle after ram_rd
- eadder_en  output  1  enable to eadder, two cycles after ram_rd
- eadder_new  output  1  first-sample flag, eadder loads mul_in only
- eadder_sel  output  1  first-sample flag, eadder loads ereg + mul_in
- eadder_out  input  39  eadder registered sum, valid one cycle after eadder_en
- ereg_out  output  39  captured energy result
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse; ereg_out is valid in the same cycle

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE and all delay stages clear.
  - ram_rd, ram_addr, square_en, eadder_en, eadder_new, eadder_sel, busy and done are all 0.
  - ereg_out is 39'd0.
  - Reset mid-frame aborts the frame with no done pulse.
- FSM states:
  - IDLE: start=1 latches base_addr, len and cont, clears index i, and goes to READ; if len=0 it goes to DONE instead.
  - READ: drives ram_rd=1 and ram_addr=base_addr+i (mod 2^ADDR_W), then increments i. When i=len-1 is issued, go to DRAIN.
  - DRAIN: waits until the last sample's eadder_en has been issued plus one cycle, then captures ereg_out<=eadder_out and goes to DONE.
  - DONE: drives done=1 for one cycle, then returns to IDLE.
- Pipeline (all outputs registered):
  - square_en(t) = ram_rd(t-1).
  - eadder_en(t) = ram_rd(t-2).
  - eadder_new(t) = first(t-2) & ~cont_l.
  - eadder_sel(t) = first(t-2) & cont_l.
  - first marks only i=0. eadder_new and eadder_sel are mutually exclusive and 0 whenever eadder_en=0.
- Timing, with start accepted at cycle 0 and N=len>0:
  - ram_rd is high cycles 1..N with ram_addr=base+0..base+N-1.
  - square_en is high cycles 2..N+1.
  - eadder_en is high cycles 3..N+2.
  - ereg_out captures eadder_out at the end of cycle N+3, so it updates and done=1 in cycle N+4.
  - busy is high cycles 1..N+3.
- len=0: no RAM reads, no enables. Cycle 1 enters DONE and done=1 in cycle 2. ereg_out becomes 0 if cont=0 and is unchanged if cont=1.
- Address wrap: base_addr+i wraps modulo 2^ADDR_W with no error.
- Width:
  - A 16-bit signed square is at most 2^30, and 256 samples give at most 2^38 < 2^39, so there is no overflow with cont=0.
  - With cont=1, overflow wraps modulo 2^39 inside the eadder and is not flagged here.
- start while busy (READ, DRAIN or DONE) is ignored; the latched parameters do not change.
- start in the same cycle that done is high is ignored; start is accepted only in IDLE.
- ereg_out changes only on a capture or on the len=0 clear; it holds otherwise.

Test Plan:
- Reset check: assert rst_n=0 mid-READ at cycle 5 -> all outputs 0 immediately, ereg_out=0, no done; after release, a new start works normally.
- Basic frame: base=0x10, len=4, cont=0, RAM[0x10..0x13]={3,-4,100,-32768}.
  - ram_rd cycles 1-4, addr 0x10-0x13.
  - eadder_new only in cycle 3.
  - done in cycle 8 with ereg_out=9+16+10000+1073741824=1073751849.
- Continue: after the previous frame, start cont=1, len=2, samples {1,2} -> eadder_sel=1 in cycle 3, eadder_new=0 throughout, ereg_out=1073751854.
- Wrap and full length: base=0xFE, len=256, all samples=-32768.
  - Addresses run 0xFE, 0xFF, 0x00 ... 0xFD.
  - done in cycle 260 with ereg_out=2^38=274877906944.
- len=0: cont=0 from ereg_out=5 -> no ram_rd, done in cycle 2, ereg_out=0; repeat with cont=1 -> ereg_out unchanged.
- Start while busy: pulse start in cycle 3 with different base/len -> ignored, original frame completes unchanged; a start in IDLE after done is accepted.

Source files
------------

// File: rtl/energy_seq_if.sv
// Bundle between the frame controller / energy datapath and energy_seq.
//   slave  : sequencer side (energy_seq)
//   master : controller + datapath side (drives start/params and eadder_out)
// Signals:
//   start, cont, base_addr, len   frame request and parameters
//   ram_rd, ram_addr              sample RAM read port
//   square_en, eadder_en          datapath enables, aligned to the RAM/square pipeline
//   eadder_new, eadder_sel        first-sample load select for the eadder
//   eadder_out                    eadder registered sum
//   ereg_out                      captured energy result
//   busy, done                    frame status
interface energy_seq_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9
);
  logic              start;
  logic              cont;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic              ram_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic              square_en;
  logic              eadder_en;
  logic              eadder_new;
  logic              eadder_sel;
  logic [38:0]       eadder_out;
  logic [38:0]       ereg_out;
  logic              busy;
  logic              done;

  modport slave (
    input  start, cont, base_addr, len, eadder_out,
    output ram_rd, ram_addr, square_en, eadder_en, eadder_new, eadder_sel,
    output ereg_out, busy, done
  );

  modport master (
    output start, cont, base_addr, len, eadder_out,
    input  ram_rd, ram_addr, square_en, eadder_en, eadder_new, eadder_sel,
    input  ereg_out, busy, done
  );
endinterface

// File: rtl/energy_seq.sv
// Energy sequencer: on start, reads len samples from sample RAM starting at base_addr and
// issues square/eadder enables aligned with the datapath pipeline, then captures the eadder
// sum into ereg_out and pulses done.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    energy_seq_if.slave (request, RAM read port, datapath enables, result, status)
module energy_seq #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9
) (
  input logic         clk,
  input logic         rst_n,
  energy_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              cont_q, cont_d;
  logic [1:0]        drain_q, drain_d;
  logic [38:0]       ereg_q, ereg_d;
  logic              rd_q, rd_d;
  logic              first_q, first_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Delay stages that align enables with the RAM -> square -> eadder pipeline.
  logic              sq_en_q;
  logic              first_p1_q;
  logic              add_en_q;
  logic              add_new_q;
  logic              add_sel_q;

  logic              last_idx;

  assign last_idx = (LEN_W'(idx_q) == len_q - LEN_W'(1));

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    cont_d  = cont_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    ereg_d  = ereg_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          base_d = bus.base_addr;
          len_d  = bus.len;
          cont_d = bus.cont;
          idx_d  = '0;
          addr_d = bus.base_addr;
          if (bus.len == '0) begin
            // Empty frame: skip straight to the capture step so done lands in cycle 2.
            state_d = StDrain;
            drain_d = 2'd2;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (last_idx) begin
          state_d = StDrain;
          drain_d = 2'd0;
        end else begin
          idx_d  = idx_q + ADDR_W'(1);
          addr_d = base_q + idx_d;
        end
      end
      StDrain: begin
        // Counter reaches 2 one cycle after the last eadder_en, when eadder_out holds the sum.
        if (drain_q == 2'd2) begin
          state_d = StDone;
          if (len_q == '0) begin
            ereg_d = cont_q ? ereg_q : '0;
          end else begin
            ereg_d = bus.eadder_out;
          end
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    rd_d    = (state_d == StRead);
    first_d = rd_d && (idx_d == '0);
    busy_d  = (state_d == StRead) || (state_d == StDrain);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      base_q     <= '0;
      len_q      <= '0;
      cont_q     <= 1'b0;
      idx_q      <= '0;
      addr_q     <= '0;
      drain_q    <= 2'd0;
      ereg_q     <= '0;
      rd_q       <= 1'b0;
      first_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sq_en_q    <= 1'b0;
      first_p1_q <= 1'b0;
      add_en_q   <= 1'b0;
      add_new_q  <= 1'b0;
      add_sel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      cont_q     <= cont_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      drain_q    <= drain_d;
      ereg_q     <= ereg_d;
      rd_q       <= rd_d;
      first_q    <= first_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sq_en_q    <= rd_q;
      first_p1_q <= first_q;
      add_en_q   <= sq_en_q;
      add_new_q  <= first_p1_q & ~cont_q;
      add_sel_q  <= first_p1_q & cont_q;
    end
  end

  assign bus.ram_rd     = rd_q;
  assign bus.ram_addr   = addr_q;
  assign bus.square_en  = sq_en_q;
  assign bus.eadder_en  = add_en_q;
  assign bus.eadder_new = add_new_q;
  assign bus.eadder_sel = add_sel_q;
  assign bus.ereg_out   = ereg_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_energy_seq.sv
module tb_energy_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  energy_seq_if #(.ADDR_W(8), .LEN_W(9)) bus ();

  energy_seq #(.ADDR_W(8), .LEN_W(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Environment: sample RAM, square block and eadder.
  logic [15:0] mem [256];
  logic [15:0] ram_q;
  logic [38:0] sq_q;

  function automatic longint sq_of(input logic [15:0] v);
    longint s;
    s = longint'($signed(v));
    return s * s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_q          <= '0;
      sq_q           <= '0;
      bus.eadder_out <= '0;
    end else begin
      if (bus.ram_rd) ram_q <= mem[bus.ram_addr];
      if (bus.square_en) sq_q <= 39'(sq_of(ram_q));
      if (bus.eadder_en) begin
        if (bus.eadder_new) bus.eadder_out <= sq_q;
        else if (bus.eadder_sel) bus.eadder_out <= bus.ereg_out + sq_q;
        else bus.eadder_out <= bus.eadder_out + sq_q;
      end
    end
  end

  // Scoreboard
  typedef struct { int cyc; logic [7:0] a; } rd_t;
  typedef struct { int cyc; bit nw; bit sl; } en_t;
  typedef struct { int cyc; logic [38:0] val; } done_t;

  rd_t   exp_rd[$];
  int    exp_sq[$];
  en_t   exp_en[$];
  done_t exp_done[$];

  int          total = 0;
  int          bad = 0;
  logic [38:0] model_e = '0;
  int          free_from = 0;
  int          busy_lo = 1;
  int          busy_hi = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor
  rd_t   m_rd;
  en_t   m_en;
  done_t m_done;
  int    m_sq;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 64'(bus.busy), 64'((cyc >= busy_lo) && (cyc <= busy_hi)));
      if (bus.ram_rd) begin
        if (exp_rd.size() == 0) chk("rd_extra", 64'(bus.ram_rd), 64'(0));
        else begin
          m_rd = exp_rd.pop_front();
          chk("rd_cycle", 64'(cyc), 64'(m_rd.cyc));
          chk("rd_addr", 64'(bus.ram_addr), 64'(m_rd.a));
        end
      end
      if (bus.square_en) begin
        if (exp_sq.size() == 0) chk("sq_extra", 64'(bus.square_en), 64'(0));
        else begin
          m_sq = exp_sq.pop_front();
          chk("sq_cycle", 64'(cyc), 64'(m_sq));
        end
      end
      if (bus.eadder_en) begin
        if (exp_en.size() == 0) chk("en_extra", 64'(bus.eadder_en), 64'(0));
        else begin
          m_en = exp_en.pop_front();
          chk("en_cycle", 64'(cyc), 64'(m_en.cyc));
          chk("en_new", 64'(bus.eadder_new), 64'(m_en.nw));
          chk("en_sel", 64'(bus.eadder_sel), 64'(m_en.sl));
        end
      end else begin
        chk("flags_idle", 64'({bus.eadder_new, bus.eadder_sel}), 64'(0));
      end
      if (bus.done) begin
        if (exp_done.size() == 0) chk("done_extra", 64'(bus.done), 64'(0));
        else begin
          m_done = exp_done.pop_front();
          chk("done_cycle", 64'(cyc), 64'(m_done.cyc));
          chk("done_ereg", 64'(bus.ereg_out), 64'(m_done.val));
        end
      end
    end
  end

  // Drives a one-cycle start; called #1 after a posedge. Model decides acceptance.
  task automatic drive_start(input logic [7:0] b, input int n, input bit c);
    int          s;
    logic [38:0] e;
    logic [7:0]  a;
    rd_t         r;
    en_t         en;
    done_t       d;
    bus.start     = 1'b1;
    bus.base_addr = b;
    bus.len       = 9'(n);
    bus.cont      = c;
    s = cyc;
    if (s >= free_from) begin
      e = c ? model_e : 39'd0;
      for (int i = 0; i < n; i++) begin
        a = b + 8'(i);
        e = e + 39'(sq_of(mem[a]));
        r.cyc = s + 1 + i;
        r.a = a;
        exp_rd.push_back(r);
        exp_sq.push_back(s + 2 + i);
        en.cyc = s + 3 + i;
        en.nw = (i == 0) && !c;
        en.sl = (i == 0) && c;
        exp_en.push_back(en);
      end
      model_e = e;
      d.cyc = (n == 0) ? s + 2 : s + n + 4;
      d.val = e;
      exp_done.push_back(d);
      busy_lo = s + 1;
      busy_hi = (n == 0) ? s + 1 : s + n + 3;
      free_from = d.cyc + 1;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 0;
    while (cyc < free_from && budget < 600) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (cyc < free_from) chk("idle_timeout", 64'(cyc), 64'(free_from));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ram_rd"}, 64'(bus.ram_rd), 64'(0));
    chk({tag, "_ram_addr"}, 64'(bus.ram_addr), 64'(0));
    chk({tag, "_square_en"}, 64'(bus.square_en), 64'(0));
    chk({tag, "_eadder_en"}, 64'(bus.eadder_en), 64'(0));
    chk({tag, "_eadder_new"}, 64'(bus.eadder_new), 64'(0));
    chk({tag, "_eadder_sel"}, 64'(bus.eadder_sel), 64'(0));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
    chk({tag, "_done"}, 64'(bus.done), 64'(0));
    chk({tag, "_ereg"}, 64'(bus.ereg_out), 64'(0));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.cont      = 1'b0;
    bus.base_addr = '0;
    bus.len       = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 7);
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame
    mem[8'h10] = 16'd3;
    mem[8'h11] = 16'hFFFC;
    mem[8'h12] = 16'd100;
    mem[8'h13] = 16'h8000;
    drive_start(8'h10, 4, 1'b0);
    wait_idle();
    chk("basic_ereg", 64'(bus.ereg_out), 64'd1073751849);

    // Continue
    mem[8'h20] = 16'd1;
    mem[8'h21] = 16'd2;
    drive_start(8'h20, 2, 1'b1);
    wait_idle();
    chk("cont_ereg", 64'(bus.ereg_out), 64'd1073751854);

    // Wrap and full length
    for (int i = 0; i < 256; i++) mem[i] = 16'h8000;
    drive_start(8'hFE, 256, 1'b0);
    wait_idle();
    chk("full_ereg", 64'(bus.ereg_out), 64'd274877906944);

    // len = 0
    mem[8'h40] = 16'd1;
    mem[8'h41] = 16'd2;
    drive_start(8'h40, 2, 1'b0);
    wait_idle();
    chk("five_ereg", 64'(bus.ereg_out), 64'd5);
    drive_start(8'h00, 0, 1'b0);
    wait_idle();
    chk("len0_clear", 64'(bus.ereg_out), 64'd0);
    drive_start(8'h40, 2, 1'b0);
    wait_idle();
    drive_start(8'h00, 0, 1'b1);
    wait_idle();
    chk("len0_hold", 64'(bus.ereg_out), 64'd5);

    // Start while busy, start in the done cycle, then start in idle
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 65535));
    drive_start(8'h30, 6, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    drive_start(8'h90, 3, 1'b1);
    while (cyc < free_from - 1) begin
      @(posedge clk);
      #1;
    end
    drive_start(8'hA0, 5, 1'b1);
    drive_start(8'h50, 3, 1'b1);
    wait_idle();

    // Reset in the middle of a read burst
    drive_start(8'h20, 10, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    exp_rd.delete();
    exp_sq.delete();
    exp_en.delete();
    exp_done.delete();
    model_e = '0;
    busy_lo = 1;
    busy_hi = 0;
    free_from = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_start(8'h70, 5, 1'b0);
    wait_idle();

    // Randomized frames
    for (int f = 0; f < 20; f++) begin
      int n;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 65535));
      n = ($urandom_range(0, 9) == 0) ? 256 : int'($urandom_range(0, 20));
      drive_start(8'($urandom), n, 1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, n + 2)) @(posedge clk);
        #1;
        drive_start(8'($urandom), int'($urandom_range(0, 20)), 1'($urandom));
      end
      wait_idle();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("left_rd", 64'(exp_rd.size()), 64'(0));
    chk("left_sq", 64'(exp_sq.size()), 64'(0));
    chk("left_en", 64'(exp_en.size()), 64'(0));
    chk("left_done", 64'(exp_done.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
